// File: rtl/reg_dump_pkg.sv
// reg_dump_pkg: shared FSM encoding, frame constants and widths for the register dump UART
package reg_dump_pkg;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} state_e;
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int FRAME_LEN_BASE = 9;
  localparam int FRAME_LEN_CSUM = 10;
  localparam int IDX_W = 4;
endpackage

// File: rtl/reg_dump_uart_tx_byte.sv
// uart_tx_byte: single-byte 8N1 serializer, LSB first, valid/ready handshake accepted back-to-back
module uart_tx_byte
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  state_e state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic tx_q, tx_d;
  logic bit_end;
  assign bit_end = baud_q == CW'(CLKS_PER_BIT - 1);
  assign ready = state_q == IDLE || (state_q == STOP_BIT && bit_end);
  assign tx = tx_q;
  // next bit/state: a new byte may be taken in the last cycle of the stop bit so bytes abut
  always_comb begin
    state_d = state_q;
    baud_d = state_q == IDLE || bit_end ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    data_d = data_q;
    tx_d = tx_q;
    if (valid && ready) begin
      state_d = START_BIT;
      data_d = data;
      bit_d = '0;
      tx_d = 1'b0;
    end else if (state_q != IDLE && bit_end) begin
      if (state_q == START_BIT || (state_q == DATA_BITS && bit_q != 3'd7)) begin
        state_d = DATA_BITS;
        bit_d = state_q == START_BIT ? 3'd0 : bit_q + 1'b1;
        tx_d = data_q[0];
        data_d = data_q >> 1;
      end else begin
        state_d = state_q == DATA_BITS ? STOP_BIT : IDLE;
        tx_d = 1'b1;
      end
    end
  end
  // state registers; reset forces the line idle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      data_q <= data_d;
      tx_q <= tx_d;
    end
  end
endmodule

// File: rtl/reg_dump_uart_tx.sv
// reg_dump_uart_tx: snapshots eight debug registers on start and sends header+regs as one UART frame; REG_DUMP_CHECKSUM_EN appends a sum byte
module reg_dump_uart_tx
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER_BYTE = HEADER_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] reg0_in,
  input  logic [7:0] reg1_in,
  input  logic [7:0] reg2_in,
  input  logic [7:0] reg3_in,
  input  logic [7:0] reg4_in,
  input  logic [7:0] reg5_in,
  input  logic [7:0] reg6_in,
  input  logic [7:0] reg7_in,
  output logic       tx,
  output logic       busy,
  output logic       done
);
  logic [7:0] shadow_q [8];
  logic [7:0] shadow_d [8];
  logic [IDX_W-1:0] idx_q, idx_d;
  logic busy_q, busy_d, done_q, done_d;
  logic byte_valid, byte_ready;
  logic [7:0] byte_data;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
  logic [7:0] csum;
  // modulo-256 sum of the snapshot, header excluded
  always_comb begin
    csum = '0;
    for (int i = 0; i < 8; i++) csum = csum + shadow_q[i];
  end
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  assign busy = busy_q;
  assign done = done_q;
  assign byte_valid = busy_q ? idx_q != LAST : start;
  // byte offered to the serializer: header on the start edge, then the byte after the one in flight
  always_comb begin
`ifdef REG_DUMP_CHECKSUM_EN
    byte_data = !busy_q ? HEADER_BYTE : idx_q == LAST - 1'b1 ? csum : shadow_q[idx_q[2:0]];
`else
    byte_data = !busy_q ? HEADER_BYTE : shadow_q[idx_q[2:0]];
`endif
  end
  // sequencer: snapshot on accepted start, advance per handshake, finish after the last stop bit
  always_comb begin
    shadow_d = shadow_q;
    idx_d = idx_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (!busy_q && start) begin
      shadow_d = '{reg0_in, reg1_in, reg2_in, reg3_in, reg4_in, reg5_in, reg6_in, reg7_in};
      idx_d = '0;
      busy_d = 1'b1;
    end else if (busy_q && byte_ready) begin
      idx_d = idx_q == LAST ? idx_q : idx_q + 1'b1;
      busy_d = idx_q != LAST;
      done_d = idx_q == LAST;
    end
  end
  // sequencer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      idx_q <= idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk(clk),
    .reset(reset),
    .valid(byte_valid),
    .data(byte_data),
    .ready(byte_ready),
    .tx(tx)
  );
endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// tb_reg_dump_uart_tx: randomized scoreboard bench decoding the UART line against a frame-level model
module tb_reg_dump_uart_tx;
  localparam int C = 4;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  localparam int FL = NB * 10 * C;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] r [8];
  logic tx, busy, done;
  int cyc = 0, checks = 0, passed = 0, free_at = 0;
  logic [7:0] exp_q [$];
  int done_q [$];

  reg_dump_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .start(start),
    .reg0_in(r[0]), .reg1_in(r[1]), .reg2_in(r[2]), .reg3_in(r[3]),
    .reg4_in(r[4]), .reg5_in(r[5]), .reg6_in(r[6]), .reg7_in(r[7]),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // called at a negedge; the model accepts a start only when no frame is in flight (done cycle counts as idle)
  task automatic issue_start();
    logic [7:0] sum;
    if (cyc >= free_at) begin
      sum = 0;
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(r[i]);
        sum = sum + r[i];
      end
`ifdef REG_DUMP_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
      free_at = cyc + FL + 1;
      done_q.push_back(free_at);
    end
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    wait_until(free_at + 2);
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic rand_regs();
    for (int i = 0; i < 8; i++) r[i] = 8'($urandom);
  endtask

  // line decoder: every bit must hold for exactly C samples
  initial begin
    logic smp [40];
    int k;
    logic [7:0] b;
    bit shape;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        smp[0] = tx;
        for (k = 1; k < 40; k++) begin
          @(negedge clk);
          if (reset) break;
          smp[k] = tx;
        end
        if (k == 40) begin
          shape = smp[0] == 1'b0 && smp[36] == 1'b1;
          for (int j = 0; j < 40; j++) if (smp[j] !== smp[(j / C) * C]) shape = 0;
          for (int j = 0; j < 8; j++) b[j] = smp[(j + 1) * C];
          chk("bit_timing", int'(shape), 1);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_byte: got %0h expected none", b);
          end else chk("frame_byte", b, exp_q.pop_front());
        end
      end
    end
  end

  // done monitor: each done must land exactly on its predicted cycle
  initial forever begin
    @(negedge clk);
    if (!reset && done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else chk("done_cycle", cyc, done_q.pop_front());
    end
  end

  initial begin
    int c, bc;
    bit quiet;
    for (int i = 0; i < 8; i++) r[i] = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    quiet = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 0;
    end
    chk("idle_quiet", int'(quiet), 1);
    for (int i = 0; i < 8; i++) r[i] = 8'(8'h11 * i);
    issue_start();
    bc = 0;
    for (int k = 0; k < FL + 20; k++) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", bc, FL);
    wait_idle();
    rand_regs();
    issue_start();
    for (int i = 0; i < 8; i++) r[i] = 8'hFF;
    wait_idle();
    rand_regs();
    c = cyc;
    issue_start();
    wait_until(c + 1 + 3 * 10 * C + 5);
    issue_start();
    wait_until(free_at);
    rand_regs();
    issue_start();
    wait_idle();
    rand_regs();
    c = cyc;
    issue_start();
    wait_until(c + 1 + 5 * 10 * C + 3 * C);
    #2 reset = 1;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_busy", busy, 0);
    exp_q.delete();
    done_q.delete();
    free_at = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (50) @(negedge clk);
    rand_regs();
    issue_start();
    wait_idle();
    for (int i = 0; i < 8; i++) r[i] = 8'hFF;
    issue_start();
    wait_idle();
    repeat (3000) begin
      if ($urandom_range(0, 99) < 3) begin
        rand_regs();
        issue_start();
      end else @(negedge clk);
    end
    wait_idle();
    repeat (10) @(negedge clk);
    chk("bytes_outstanding", exp_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/reg_dump_uart_tx.md
Name: reg_dump_uart_tx

Overview:
Reader side of the register-file debug taps. On a start pulse it snapshots the eight 8-bit register debug outputs and sends them off-chip as one UART frame (8N1, LSB first). The host sees the architectural register state on the FPGA board. Sits beside the register file in the FPGA top level and drives the board UART TX pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2
HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request one dump; sampled only in IDLE
reg0_in .. reg7_in  input  8 each  register file debug outputs, registers 0..7
tx  output  1  UART serial line; idle high
busy  output  1  high from the cycle after start is accepted until the frame completes
done  output  1  one-cycle pulse when the final stop bit has completed

Behaviour:
- Reset (async, active-high): tx=1, busy=0, done=0. FSM goes to IDLE. Baud, bit and byte counters clear. Snapshot registers clear to 0. Reset asserted mid-frame aborts the frame and drives tx high immediately. There is no resumption.
- IDLE: tx=1, busy=0. If start=1 on a clock edge:
  - latch reg0_in..reg7_in into the shadow registers on that same edge;
  - byte index = 0;
  - go to START_BIT;
  - busy=1 from the next cycle.
- Frame order: HEADER_BYTE, shadow0, shadow1, ... shadow7. That is 9 bytes, or 10 with the optional checksum.
- Input changes after the snapshot edge do not affect the frame in flight.
- Per byte, each bit is held for exactly CLKS_PER_BIT cycles:
  - START_BIT: tx=0;
  - DATA_BITS: tx = data[bit_idx], bit_idx 0..7, LSB first;
  - STOP_BIT: tx=1.
- Bytes are back-to-back, with no idle gap. The next start bit begins the cycle after the previous stop bit's last cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit transition happens when the counter equals CLKS_PER_BIT-1.
- After the last stop bit of the last byte: next cycle FSM is in IDLE, busy=0, done=1 for exactly one cycle.
- A start asserted while busy is ignored. It is not queued.
- A start in the same cycle done=1 (FSM already in IDLE) is accepted.
- Frame latency from the start edge to done: (number of bytes × 10 × CLKS_PER_BIT) + 1 cycles.
- tx is driven from a flop. There is no combinational path from any input to tx.

Optional Feature:
Macro: REG_DUMP_CHECKSUM_EN.
- Defined: a 10th byte is appended after shadow7. It is the 8-bit sum, modulo 256, of shadow0..shadow7; the header is excluded.
- Not defined: the frame is exactly 9 bytes and no adder logic is present.

Decomposition:
Package reg_dump_pkg holds:
- the FSM state encoding: IDLE, START_BIT, DATA_BITS, STOP_BIT;
- the header default 8'hA5;
- the frame-length constants: 9 and 10;
- the byte-index width: 4 bits.

One natural sub-module is uart_tx_byte, a single-byte 8N1 serializer with a valid/ready handshake, parameterised by CLKS_PER_BIT. The top level keeps the snapshot, the byte sequencer, checksum and done/busy generation.

Test Plan:
Run all scenarios with CLKS_PER_BIT=4.
1. After reset: tx=1, busy=0, done=0. Holding start=0 for 100 cycles shows no tx activity.
2. Regs = 00,11,22,...,77; pulse start.
   - Decoded bytes are A5,00,11,22,33,44,55,66,77.
   - Each bit is exactly 4 cycles; busy is high for 360 cycles.
   - done pulses once, 361 cycles after the start edge.
   - With REG_DUMP_CHECKSUM_EN, a 10th byte DC follows and done comes at 401.
3. Change all reg inputs to FF one cycle after start → frame still carries the original snapshot values.
4. Pulse start again at byte 3 of a frame → ignored; exactly one frame is sent. A start in the done cycle → a second frame begins immediately.
5. Assert reset during shadow4's data bits → tx=1 and busy=0 asynchronously. After release, a new start yields a complete, correct frame.
6. Regs all FF with REG_DUMP_CHECKSUM_EN → checksum byte F8, confirming 8-bit wrap-around.
